// File: rtl/apb_cmd_master.sv
// apb_cmd_master: buffers read/write commands in a small FIFO and replays them
// as APB transfers, returning one response (rdata/err) per command.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC
// wait states with an error response; without it ACCESS waits for pready.
module apb_cmd_master #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [NUM_SLV-1:0]      psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SEL_W  = $clog2(NUM_SLV);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_AW = PTR_W + 1;

    // Elaboration-time parameter sanity checks
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (NUM_SLV < 2 || (NUM_SLV & (NUM_SLV - 1)) != 0) begin : g_bad_ns
        $error("NUM_SLV must be a power of 2, at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    cmd_t              mem [FIFO_DEPTH];
    cmd_t              cmd_in;
    cmd_t              head;
    logic [PTR_AW-1:0] wr_ptr;
    logic [PTR_AW-1:0] rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    state_t            state;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = !empty && ((state == IDLE) || (state == RESP && rsp_ready));
    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign cmd_in    = '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};

    // Command storage (payload needs no reset; validity lives in the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= cmd_in;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_AW'(1);
        end
    end

    // APB sequencing FSM with registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: ;
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        state     <= RESP;
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state     <= RESP;
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Launch the FIFO head; overrides the IDLE/RESP transition above
            if (pop) begin
                state   <= SETUP;
                psel    <= NUM_SLV'(1) << head.addr[ADDR_WIDTH-1 -: SEL_W];
                penable <= 1'b0;
                pwrite  <= head.wr;
                paddr   <= head.addr;
                pwdata  <= head.wdata;
                pstrb   <= head.wr ? head.strb : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed commands push expected
// responses; an APB slave model and a response monitor check independently.
module tb_apb_cmd_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned NS = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [NS-1:0] psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb_cmd_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS),
        .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    pstrb;
        logic [NS-1:0] psel;
        int            waits;
        logic [DW-1:0] rdata;
        logic          slverr;
    } txn_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            pen;
    } exp_t;

    txn_t slv_q[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   setup_cyc = 0;
    int   pen_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave model: applies the queued wait states/return data, checks bus
    always @(negedge clk) begin
        txn_t cur;
        if (rst) begin
            acc_cnt = 0; setup_cyc = 0;
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
        end else if (psel != '0 && !penable) begin
            setup_cyc++;
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
        end else if (psel != '0 && penable) begin
            if (slv_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_xfer: paddr 0x%0h with no command queued", paddr);
                pready = 1'b1; pslverr = 1'b0; prdata = '0;
            end else begin
                cur = slv_q[0];
                if (acc_cnt == 0) begin
                    chk("setup_cycles", 64'(setup_cyc), 64'(1));
                    setup_cyc = 0;
                end
                chk("apb_ctrl", 64'({psel, paddr, pwrite, pstrb, (cur.wr ? pwdata : 32'h0)}),
                    64'({cur.psel, cur.addr, cur.wr, cur.pstrb, (cur.wr ? cur.wdata : 32'h0)}));
                if (acc_cnt == cur.waits) begin
                    pready = 1'b1; prdata = cur.rdata; pslverr = cur.slverr;
                    void'(slv_q.pop_front());
                    acc_cnt = 0;
                end else begin
                    pready = 1'b0; prdata = '0; pslverr = 1'b0;
                    acc_cnt++;
                end
            end
        end else begin
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
            if (acc_cnt != 0) begin
                void'(slv_q.pop_front());
                acc_cnt = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pen_cyc = 0;
        end else begin
            if (penable) pen_cyc++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: err %0b rdata 0x%0h with none expected",
                             rsp_err, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err_rdata", 64'({rsp_err, rsp_rdata}), 64'({e.err, e.rdata}));
                    chk("penable_cycles", 64'(pen_cyc), 64'(e.pen));
                    chk("bus_idle_in_resp", 64'({psel, penable}), 64'(0));
                end
                pen_cyc = 0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] strb, input int waits, input logic [DW-1:0] rd,
                         input logic slverr, input logic [NS-1:0] epsel,
                         input logic [DW-1:0] erdata, input logic eerr, input int epen);
        bit ok = 1'b0;
        slv_q.push_back('{wr: wr, addr: addr, wdata: wdata, pstrb: (wr ? strb : 4'h0),
                          psel: epsel, waits: waits, rdata: rd, slverr: slverr});
        exp_q.push_back('{err: eerr, rdata: erdata, pen: epen});
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_accept: addr 0x%0h not accepted within 200 cycles", addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_apb", 64'({psel, penable, pwrite, paddr, pstrb}), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        chk("reset_pwdata", 64'(pwdata), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;

        // Write, zero wait states; psel appears one edge after acceptance
        issue(1'b1, 16'h4010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 4'b0010, 32'h0, 1'b0, 1);
        @(negedge clk);
        chk("psel_before_pop", 64'(psel), 64'(0));
        @(negedge clk);
        chk("psel_after_pop", 64'({psel, penable}), 64'({4'b0010, 1'b0}));
        drain();

        // Read with 3 wait states
        issue(1'b0, 16'hC000, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, 4'b1000, 32'h12345678, 1'b0, 4);
        drain();

        // Slave error on a read, followed directly by a queued write
        issue(1'b0, 16'h0004, 32'h0, 4'h0, 1, 32'hA5A5A5A5, 1'b1, 4'b0001, 32'hA5A5A5A5, 1'b1, 2);
        issue(1'b1, 16'h7FFC, 32'h0000BEEF, 4'h3, 0, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h0, 1'b0, 1);
        drain();

        // FIFO fill: one command in flight plus four queued while responses stall
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0000, 32'h0,        4'h0, 0, 32'h11111111, 1'b0, 4'b0001, 32'h11111111, 1'b0, 1);
        issue(1'b1, 16'h4444, 32'h22222222, 4'hC, 1, 32'h0,        1'b0, 4'b0010, 32'h0,        1'b0, 2);
        issue(1'b0, 16'h8888, 32'h0,        4'h0, 2, 32'h33333333, 1'b0, 4'b0100, 32'h33333333, 1'b0, 3);
        issue(1'b1, 16'hCCCC, 32'h44444444, 4'h1, 0, 32'h0,        1'b1, 4'b1000, 32'h0,        1'b1, 1);
        issue(1'b0, 16'h1234, 32'h0,        4'h0, 0, 32'h55555555, 1'b0, 4'b0001, 32'h55555555, 1'b0, 1);
        chk("cmd_ready_full", 64'(cmd_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("rsp_held_while_stalled", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, 32'h11111111}));
        rsp_ready = 1'b1;
        drain();

        // Reset during ACCESS with two commands queued
        issue(1'b0, 16'h8000, 32'h0,        4'h0, 50, 32'h66666666, 1'b0, 4'b0100, 32'h66666666, 1'b0, 51);
        issue(1'b1, 16'h4000, 32'h77777777, 4'hF, 0,  32'h0,        1'b0, 4'b0010, 32'h0,        1'b0, 1);
        issue(1'b1, 16'hC000, 32'h88888888, 4'hF, 0,  32'h0,        1'b0, 4'b1000, 32'h0,        1'b0, 1);
        chk("in_access_before_reset", 64'({psel, penable}), 64'({4'b0100, 1'b1}));
        rst = 1'b1;
        exp_q.delete();
        slv_q.delete();
        @(negedge clk);
        chk("abort_apb", 64'({psel, penable, pwrite, paddr, pstrb}), 64'(0));
        chk("abort_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        chk("abort_pwdata", 64'(pwdata), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("empty_after_abort", 64'({cmd_ready, psel, rsp_valid}), 64'({1'b1, 4'b0000, 1'b0}));

        // Recovery transfer after the abort
        issue(1'b1, 16'hC008, 32'h01020304, 4'h5, 2, 32'hFFFFFFFF, 1'b0, 4'b1000, 32'h0, 1'b0, 3);
        drain();

`ifdef APB_TIMEOUT_EN
        // pready never returns: error response after TIMEOUT_CYC ACCESS cycles
        issue(1'b0, 16'h4100, 32'h0, 4'h0, 1000, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h0, 1'b1, 16);
        drain();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("slave_queue_empty", 64'(slv_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
